edge_event_monitor: RTL and testbench

//   Downstream consumer of toggle/edge-driven registers such as the d/e/g/h flops of the always-block diags.

---
 rtl/edge_event_monitor.sv | 189 ++++++++++++++++++
 tb/tb_edge_event_monitor.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/edge_event_monitor.sv
// edge_event_monitor
//   Samples CHANNELS single-bit signals through a two-stage pipeline, detects
//   qualified rising/falling edges, keeps per-channel saturating edge counters
//   and queues one record per edge into a small FIFO drained via valid/ready.
//   Optional feature macro: EDGE_MON_TIMESTAMP_EN (adds a free-running
//   timestamp captured into each record and driven on evt_ts).

module edge_event_monitor #(
   parameter int CHANNELS   = 4,
   parameter int CNT_W      = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int TS_W       = 16
) (
   input  logic                                             clock,
   input  logic                                             reset,
   input  logic [CHANNELS-1:0]                              sig_in,
   input  logic [1:0]                                       edge_sel,
   input  logic                                             clear,
   input  logic                                             evt_ready,
   output logic                                             evt_valid,
   output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] evt_chan,
   output logic                                             evt_rise,
   output logic [TS_W-1:0]                                  evt_ts,
   output logic [CHANNELS*CNT_W-1:0]                        count_out,
   output logic                                             overflow
);

   localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int AW = $clog2(FIFO_DEPTH);

   logic [CHANNELS-1:0] r_s1, r_s2, r_pend, r_pend_rise;
   logic                r_primed;
   logic [CHANNELS*CNT_W-1:0] r_cnt;
   logic                r_overflow;

   logic [CW-1:0]       r_fifo_chan [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] r_fifo_rise;
   logic [AW-1:0]       r_wr_ptr, r_rd_ptr;
   logic [AW:0]         r_count;

   logic [CHANNELS-1:0] w_edge, w_rise, w_qual;
   logic [CHANNELS-1:0] w_grant_oh, w_push_oh, w_busy, w_accept;
   logic [CW-1:0]       w_grant;
   logic                w_full, w_empty, w_pop, w_push, w_drop;

   // Edge detection on the s1/s2 pipeline, qualified by edge_sel; silent until primed
   always_comb begin
      w_edge = '0;
      w_rise = '0;
      if (r_primed) begin
         w_edge = r_s1 ^ r_s2;
         w_rise = r_s1 & ~r_s2;
      end else begin
         w_edge = '0;
         w_rise = '0;
      end
      w_qual = (w_rise & {CHANNELS{edge_sel[0]}}) |
               (w_edge & ~w_rise & {CHANNELS{edge_sel[1]}});
   end

   // FIFO status, lowest-index pending arbitration and drop detection
   always_comb begin
      w_empty    = (r_count == {(AW+1){1'b0}});
      w_full     = (r_count == (AW+1)'(FIFO_DEPTH));
      w_pop      = ~w_empty & evt_ready;
      w_grant_oh = r_pend & (~r_pend + CHANNELS'(1));
      w_grant    = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         w_grant = w_grant | (w_grant_oh[i] ? CW'(i) : {CW{1'b0}});
      end
      w_push     = (|r_pend) & (~w_full | w_pop);
      w_push_oh  = w_push ? w_grant_oh : {CHANNELS{1'b0}};
      // A channel is busy if its pending record is not leaving this cycle
      w_busy     = r_pend & ~w_push_oh;
      w_accept   = w_qual & ~w_busy;
      w_drop     = |(w_qual & w_busy);
   end

   // Input sampling pipeline with one-cycle priming after reset
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_s1     <= '0;
         r_s2     <= '0;
         r_primed <= 1'b0;
      end else if (!r_primed) begin
         r_s1     <= sig_in;
         r_s2     <= sig_in;
         r_primed <= 1'b1;
      end else begin
         r_s1     <= sig_in;
         r_s2     <= r_s1;
      end
   end

   // Per-channel pending flags; a record leaving this cycle frees the slot for a new edge
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_pend      <= '0;
         r_pend_rise <= '0;
      end else begin
         r_pend      <= (r_pend & ~w_push_oh) | w_qual;
         r_pend_rise <= (r_pend_rise & ~w_accept) | (w_rise & w_accept);
      end
   end

   // Saturating edge counters; clear takes priority over a same-cycle increment
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (clear) begin
         r_cnt <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (w_qual[i] && (r_cnt[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
               r_cnt[i*CNT_W +: CNT_W] <= r_cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
            end
         end
      end
   end

   // Sticky overflow flag for dropped records
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_overflow <= 1'b0;
      end else if (clear) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end
   end

   // Event FIFO storage and pointers; push+pop together keeps occupancy
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_fifo_rise <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_fifo_chan[i] <= '0;
         end
      end else begin
         if (w_push) begin
            r_fifo_chan[r_wr_ptr] <= w_grant;
            r_fifo_rise[r_wr_ptr] <= |(r_pend_rise & w_grant_oh);
            r_wr_ptr              <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + (AW+1)'(1);
         end else if (!w_push && w_pop) begin
            r_count <= r_count - (AW+1)'(1);
         end
      end
   end

`ifdef EDGE_MON_TIMESTAMP_EN
   logic [TS_W-1:0] r_ts;
   logic [TS_W-1:0] r_fifo_ts [FIFO_DEPTH];

   // Free-running timestamp and per-record capture at push time
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_ts <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_fifo_ts[i] <= '0;
         end
      end else begin
         r_ts <= r_ts + TS_W'(1);
         if (w_push) begin
            r_fifo_ts[r_wr_ptr] <= r_ts;
         end
      end
   end

   assign evt_ts = r_fifo_ts[r_rd_ptr];
`else
   assign evt_ts = '0;
`endif

   assign evt_valid = ~w_empty;
   assign evt_chan  = r_fifo_chan[r_rd_ptr];
   assign evt_rise  = r_fifo_rise[r_rd_ptr];
   assign count_out = r_cnt;
   assign overflow  = r_overflow;

endmodule

// File: tb/tb_edge_event_monitor.sv
// Scoreboard bench for edge_event_monitor: the stimulus process pushes
// expected {rise, chan} records; a negedge monitor pops and compares each
// record the DUT hands over. Counters/overflow are checked directly.

module tb_edge_event_monitor;

   localparam int CH = 6;
   localparam int CW = 3;
   localparam int CNT_W = 8;

   logic                clock = 1'b0;
   logic                reset;
   logic [CH-1:0]       sig_in;
   logic [1:0]          edge_sel;
   logic                clear;
   logic                evt_ready;
   logic                evt_valid;
   logic [CW-1:0]       evt_chan;
   logic                evt_rise;
   logic [15:0]         evt_ts;
   logic [CH*CNT_W-1:0] count_out;
   logic                overflow;

   int n_checks = 0;
   int n_pass   = 0;
   logic [CW:0] exp_q [$];

   edge_event_monitor #(.CHANNELS(CH), .CNT_W(CNT_W), .FIFO_DEPTH(4), .TS_W(16)) dut (
      .clock(clock), .reset(reset), .sig_in(sig_in), .edge_sel(edge_sel),
      .clear(clear), .evt_ready(evt_ready), .evt_valid(evt_valid),
      .evt_chan(evt_chan), .evt_rise(evt_rise), .evt_ts(evt_ts),
      .count_out(count_out), .overflow(overflow)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic expect_rec(input int ch, input logic rise);
      exp_q.push_back({rise, CW'(ch)});
   endtask

   task automatic drain(input string name);
      int k = 0;
      while (exp_q.size() != 0 && k < 60) begin
         tick();
         k++;
      end
      check(name, 64'(exp_q.size()), 64'd0);
   endtask

   function automatic logic [CNT_W-1:0] cnt(input int ch);
      return count_out[ch*CNT_W +: CNT_W];
   endfunction

   // Monitor: a record is consumed at the next posedge when valid & ready
   always @(negedge clock) begin
      if (!reset && evt_valid && evt_ready) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL unexpected_record: got chan %0d rise %0b expected none", evt_chan, evt_rise);
         end else begin
            logic [CW:0] e;
            e = exp_q.pop_front();
            if ({evt_rise, evt_chan} === e) n_pass++;
            else $display("FAIL record: got rise %0b chan %0d expected rise %0b chan %0d",
                          evt_rise, evt_chan, e[CW], e[CW-1:0]);
         end
`ifndef EDGE_MON_TIMESTAMP_EN
         check("evt_ts_zero", 64'(evt_ts), 64'd0);
`endif
      end
   end

   initial begin
      reset = 1'b1; sig_in = 6'h3F; edge_sel = 2'b01; clear = 1'b0; evt_ready = 1'b0;
      repeat (3) tick();
      check("reset_valid", 64'(evt_valid), 64'd0);
      check("reset_counts", 64'(count_out), 64'd0);
      check("reset_ovf", 64'(overflow), 64'd0);

      // 1: priming with all inputs high must not produce edges
      reset = 1'b0;
      repeat (4) tick();
      check("prime_valid", 64'(evt_valid), 64'd0);
      check("prime_counts", 64'(count_out), 64'd0);

      // 2: fall ignored in rise-only mode, then ch0 rise
      sig_in = 6'h3E;
      repeat (3) tick();
      check("fall_ignored_cnt0", 64'(cnt(0)), 64'd0);
      check("fall_ignored_valid", 64'(evt_valid), 64'd0);
      evt_ready = 1'b1;
      sig_in = 6'h3F;
      expect_rec(0, 1'b1);
      tick();                       // edge k samples the change
      tick();                       // edge k+1 updates the counter
      check("t2_cnt0", 64'(cnt(0)), 64'd1);
      drain("t2_drain");

      // 3: ch1 and ch2 rise together -> ch1 then ch2
      sig_in = 6'h39;
      repeat (3) tick();
      sig_in = 6'h3F;
      expect_rec(1, 1'b1);
      expect_rec(2, 1'b1);
      repeat (2) tick();
      check("t3_cnt1", 64'(cnt(1)), 64'd1);
      check("t3_cnt2", 64'(cnt(2)), 64'd1);
      drain("t3_drain");
      check("t3_ovf", 64'(overflow), 64'd0);

      // 4: five falling edges with consumer stalled; FIFO holds 4, ch4 stays pending
      edge_sel = 2'b11;
      evt_ready = 1'b0;
      sig_in = 6'h20;
      for (int c = 0; c < 5; c++) expect_rec(c, 1'b0);
      repeat (8) tick();
      check("t4_valid", 64'(evt_valid), 64'd1);
      check("t4_head_chan", 64'(evt_chan), 64'd0);
      check("t4_head_rise", 64'(evt_rise), 64'd0);
      check("t4_ovf_before", 64'(overflow), 64'd0);
      sig_in = 6'h30;               // ch4 rises while its fall record is still pending
      repeat (2) tick();
      check("t4_ovf_after", 64'(overflow), 64'd1);
      check("t4_head_stable", 64'(evt_chan), 64'd0);
      check("t4_cnt0", 64'(cnt(0)), 64'd2);
      check("t4_cnt3", 64'(cnt(3)), 64'd1);
      check("t4_cnt4", 64'(cnt(4)), 64'd2);
      evt_ready = 1'b1;
      drain("t4_drain");
      tick();
      check("t4_empty", 64'(evt_valid), 64'd0);

      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("clear_counts", 64'(count_out), 64'd0);
      check("clear_ovf", 64'(overflow), 64'd0);

      // 5: 300 toggles on ch3 saturate its counter at 255
      for (int t = 0; t < 300; t++) begin
         sig_in[3] = ~sig_in[3];
         expect_rec(3, sig_in[3]);
         repeat (2) tick();
      end
      tick();
      check("t5_sat", 64'(cnt(3)), 64'd255);
      check("t5_ovf", 64'(overflow), 64'd0);
      check("t5_cnt5", 64'(cnt(5)), 64'd0);
      drain("t5_drain");
      sig_in[3] = ~sig_in[3];
      expect_rec(3, sig_in[3]);
      tick();                       // edge k
      clear = 1'b1;
      tick();                       // edge k+1: clear wins over increment
      clear = 1'b0;
      check("t5_clear_wins", 64'(cnt(3)), 64'd0);
      check("t5_clear_ovf", 64'(overflow), 64'd0);
      drain("t5_clear_drain");

      // Reset mid-operation drops queued records
      evt_ready = 1'b0;
      sig_in[0] = ~sig_in[0];
      repeat (4) tick();
      check("mid_valid_before", 64'(evt_valid), 64'd1);
      reset = 1'b1;
      #1;
      check("mid_async_valid", 64'(evt_valid), 64'd0);
      check("mid_async_counts", 64'(count_out), 64'd0);
      exp_q.delete();
      tick();
      reset = 1'b0;
      evt_ready = 1'b1;
      repeat (4) tick();
      check("mid_reprime_valid", 64'(evt_valid), 64'd0);
      check("mid_reprime_counts", 64'(count_out), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
